obstacle_mover: RTL
===================

OBSTACLE_MOVER -- requirements
Module: obstacle_mover

Interface
REQ-001 The block SHALL have parameter SPRITE_W, default 4, meaning sprite width in pixels (1..8).
REQ-002 The block SHALL have parameter SPRITE_H, default 4, meaning sprite height in pixels (1..8).
REQ-003 The block SHALL have parameter X_START, default 10, meaning sprite left column after reset.
REQ-004 The block SHALL have parameter Y_START, default 58, meaning sprite top row (fixed).
REQ-005 The block SHALL have parameters X_MIN, default 0, and X_MAX, default 156, meaning the legal left-column range (inclusive).
REQ-006 The block SHALL have parameter TICKS_PER_FRAME, default 833333, meaning clocks per frame (60 Hz at 50 MHz).
REQ-007 The block SHALL have parameter FRAMES_PER_STEP, default 15, meaning frames per 1-pixel move.
REQ-008 The block SHALL have parameter COLOUR, default 3'd2, meaning sprite draw colour.
REQ-009 The block SHALL have ports: clock in 1 system clock; resetn in 1 synchronous active-low reset; enable in 1 motion enable; plot_ready in 1 downstream accepts pixel; x out 8 pixel column; y out 7 pixel row; colour out 3 pixel colour; plot out 1 pixel valid; busy out 1 erase/draw in progress; done out 1 one-cycle step-complete pulse; wrapped out 1 one-cycle boundary pulse; overrun out 1 sticky missed-step flag.

Function
REQ-010 The block SHALL use a frame counter that, while enable=1, counts TICKS_PER_FRAME-1 down to 0 and reloads, asserting an internal frame tick for 1 cycle at 0; enable=0 SHALL hold the count.
REQ-011 The block SHALL use a step counter that counts frame ticks FRAMES_PER_STEP-1 down to 0 and asserts an internal step pulse for 1 cycle at 0.
REQ-012 The block SHALL implement FSM states INIT, IDLE, ERASE, MOVE, DRAW; after reset it SHALL enter INIT, draw the sprite at (X_START,Y_START), then enter IDLE.
REQ-013 IDLE SHALL transition to ERASE on a step pulse.
REQ-014 ERASE SHALL emit SPRITE_W*SPRITE_H pixels with colour=0 at the current position, then enter MOVE.
REQ-015 MOVE SHALL last exactly 1 cycle, update the position by one pixel in the current direction, and enter DRAW.
REQ-016 DRAW SHALL emit SPRITE_W*SPRITE_H pixels with colour=COLOUR, then return to IDLE with done=1 for 1 cycle.
REQ-017 Pixels SHALL be emitted in raster order (column fastest), with x=pos_x+col and y=Y_START+row, all widths truncated to port width.
REQ-018 The handshake SHALL hold plot=1 with stable x/y/colour until a cycle with plot_ready=1; the pixel SHALL transfer on that edge and the next pixel SHALL follow with no bubble.
REQ-019 busy SHALL be 1 in INIT, ERASE, MOVE and DRAW, and 0 in IDLE.
REQ-020 A step pulse arriving while busy=1 SHALL be dropped and SHALL set overrun, which SHALL clear only on reset.
REQ-021 Default motion SHALL be +1 per step; when pos_x=X_MAX, MOVE SHALL load X_MIN and pulse wrapped.
REQ-022 When enable falls mid-ERASE or mid-DRAW, the block SHALL complete the current sequence; only the counters freeze.

Reset
REQ-023 When resetn=0 at a clock edge, the block SHALL set pos_x=X_START, direction=+1, plot=0, colour=0, busy=0, done=0, wrapped=0, overrun=0, both counters to full reload values, and state INIT.
REQ-024 Reset mid-ERASE or mid-DRAW SHALL abandon the sequence without emitting further pixels; INIT SHALL redraw at X_START.

Configuration
REQ-025 Macro OBSTACLE_BOUNCE_EN, when defined, SHALL make the sprite reverse direction at the boundaries instead of wrapping: at X_MAX with direction +1, and at X_MIN with direction -1, MOVE SHALL flip direction, step one pixel inward, and pulse wrapped.
REQ-026 When OBSTACLE_BOUNCE_EN is undefined, the block SHALL use the wrap behaviour of REQ-021, direction SHALL be constant +1, and no direction register SHALL be synthesised.

Verification
REQ-027 Bench SHALL cover reset with SPRITE_W=SPRITE_H=2 and plot_ready=1 -> plot for 4 cycles: (10,58),(11,58),(10,59),(11,59) with colour 2, then busy=0.
REQ-028 Bench SHALL cover TICKS_PER_FRAME=4, FRAMES_PER_STEP=2, enable=1 -> first step 8 cycles after enable; 4 erase pixels at x=10 with colour 0; then 4 draw pixels at x=11; done pulse.
REQ-029 Bench SHALL cover plot_ready toggling 1,0,1,0 during DRAW -> each pixel held until accepted; exactly 4 transfers; no pixel duplicated or skipped.
REQ-030 Bench SHALL cover X_START=X_MAX=156 with a step -> erase at 156, draw at X_MIN=0, wrapped=1 for 1 cycle (with OBSTACLE_BOUNCE_EN defined: draw at 155, subsequent steps decrement).
REQ-031 Bench SHALL cover TICKS_PER_FRAME=1, FRAMES_PER_STEP=1 with plot_ready=0 -> step during ERASE dropped, overrun=1 and held until resetn=0.
REQ-032 Bench SHALL cover resetn=0 on the 2nd ERASE pixel -> plot=0 the next cycle, then INIT redraws at (10,58), overrun=0.

Source files
------------

// File: rtl/obstacle_mover.sv
// Frame-timed horizontal sprite mover: erase, step one pixel, redraw via plot/plot_ready.
// Optional OBSTACLE_BOUNCE_EN reverses direction at the edges instead of wrapping.
module obstacle_mover #(
   parameter int         SPRITE_W        = 4,
   parameter int         SPRITE_H        = 4,
   parameter int         X_START         = 10,
   parameter int         Y_START         = 58,
   parameter int         X_MIN           = 0,
   parameter int         X_MAX           = 156,
   parameter int         TICKS_PER_FRAME = 833333,
   parameter int         FRAMES_PER_STEP = 15,
   parameter logic [2:0] COLOUR          = 3'd2
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       enable,
   input  logic       plot_ready,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done,
   output logic       wrapped,
   output logic       overrun
);

   localparam int FW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
   localparam int SW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [FW-1:0] F_LOAD   = FW'(TICKS_PER_FRAME - 1);
   localparam logic [SW-1:0] S_LOAD   = SW'(FRAMES_PER_STEP - 1);
   localparam logic [2:0]    COL_LAST = 3'(SPRITE_W - 1);
   localparam logic [2:0]    ROW_LAST = 3'(SPRITE_H - 1);
   localparam logic [7:0]    X_LO     = 8'(X_MIN);
   localparam logic [7:0]    X_HI     = 8'(X_MAX);
   localparam logic [7:0]    X_INIT   = 8'(X_START);
   localparam logic [6:0]    Y_TOP    = 7'(Y_START);

   typedef enum logic [2:0] {INIT, IDLE, ERASE, MOVE, DRAW} state_t;

   state_t        state, state_n;
   logic [FW-1:0] frame_cnt;
   logic [SW-1:0] step_cnt;
   logic          frame_tick, step;
   logic [7:0]    pos_x, pos_n, new_x;
   logic [2:0]    col, row, col_n, row_n, ncol, nrow;
   logic          last, edge_hit;
   logic [7:0]    x_n;
   logic [6:0]    y_n;
   logic [2:0]    colour_n;
   logic          plot_n, busy_n, done_n, wrapped_n, overrun_n;

   assign frame_tick = enable && (frame_cnt == '0);
   assign step       = frame_tick && (step_cnt == '0);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         frame_cnt <= F_LOAD;
         step_cnt  <= S_LOAD;
      end else begin
         if (enable)
            frame_cnt <= frame_tick ? F_LOAD : frame_cnt - 1'b1;
         if (frame_tick)
            step_cnt <= (step_cnt == '0) ? S_LOAD : step_cnt - 1'b1;
      end
   end

`ifdef OBSTACLE_BOUNCE_EN
   logic dir_neg, dir_n;

   always_ff @(posedge clock) begin
      if (!resetn)
         dir_neg <= 1'b0;
      else if (state == MOVE)
         dir_neg <= dir_n;
   end

   always_comb begin
      dir_n    = dir_neg;
      edge_hit = 1'b0;
      new_x    = dir_neg ? pos_x - 8'd1 : pos_x + 8'd1;
      if (!dir_neg && pos_x == X_HI) begin
         dir_n    = 1'b1;
         edge_hit = 1'b1;
         new_x    = pos_x - 8'd1;
      end else if (dir_neg && pos_x == X_LO) begin
         dir_n    = 1'b0;
         edge_hit = 1'b1;
         new_x    = pos_x + 8'd1;
      end
   end
`else
   always_comb begin
      edge_hit = (pos_x == X_HI);
      new_x    = edge_hit ? X_LO : pos_x + 8'd1;
   end
`endif

   always_comb begin
      last      = (col == COL_LAST) && (row == ROW_LAST);
      ncol      = (col == COL_LAST) ? 3'd0 : col + 3'd1;
      nrow      = (col == COL_LAST) ? row + 3'd1 : row;
      state_n   = state;
      pos_n     = pos_x;
      col_n     = col;
      row_n     = row;
      plot_n    = plot;
      x_n       = x;
      y_n       = y;
      colour_n  = colour;
      done_n    = 1'b0;
      wrapped_n = 1'b0;
      overrun_n = overrun | (step && state != IDLE);
      unique case (state)
         IDLE: begin
            if (step) begin
               state_n  = ERASE;
               plot_n   = 1'b1;
               x_n      = pos_x;
               y_n      = Y_TOP;
               colour_n = 3'd0;
            end
         end
         MOVE: begin
            pos_n     = new_x;
            wrapped_n = edge_hit;
            state_n   = DRAW;
            plot_n    = 1'b1;
            x_n       = new_x;
            y_n       = Y_TOP;
            colour_n  = COLOUR;
         end
         INIT, ERASE, DRAW: begin
            // INIT leaves reset with plot low, so it loads its first pixel here
            if (!plot) begin
               plot_n   = 1'b1;
               x_n      = pos_x + {5'd0, col};
               y_n      = Y_TOP + {4'd0, row};
               colour_n = (state == ERASE) ? 3'd0 : COLOUR;
            end else if (plot_ready) begin
               if (last) begin
                  plot_n  = 1'b0;
                  col_n   = 3'd0;
                  row_n   = 3'd0;
                  state_n = (state == ERASE) ? MOVE : IDLE;
                  done_n  = (state == DRAW);
               end else begin
                  col_n = ncol;
                  row_n = nrow;
                  x_n   = pos_x + {5'd0, ncol};
                  y_n   = Y_TOP + {4'd0, nrow};
               end
            end
         end
         default: state_n = INIT;
      endcase
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state   <= INIT;
         pos_x   <= X_INIT;
         col     <= 3'd0;
         row     <= 3'd0;
         plot    <= 1'b0;
         x       <= 8'd0;
         y       <= 7'd0;
         colour  <= 3'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wrapped <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= state_n;
         pos_x   <= pos_n;
         col     <= col_n;
         row     <= row_n;
         plot    <= plot_n;
         x       <= x_n;
         y       <= y_n;
         colour  <= colour_n;
         busy    <= busy_n;
         done    <= done_n;
         wrapped <= wrapped_n;
         overrun <= overrun_n;
      end
   end

endmodule
